// File: rtl/wb_sram_arb_pkg.sv
// Shared definitions for the Wishbone-to-SRAM arbiter: FSM encodings and defaults.
package wb_sram_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [31:0] DEF_BASE_ADR    = 32'h8000_0000;
  localparam logic [31:0] DEF_ADR_MASK    = 32'hFF00_0000;
  localparam int          DEF_WAIT_STATES = 2;

endpackage

// File: rtl/wb_sram_arb_if.sv
// Bus bundle: N Wishbone initiator ports plus the single-port SRAM side.
interface wb_sram_arb_if #(
  parameter int N_INITIATORS = 3,
  parameter int ADDR_BITS    = 8
);
  logic [N_INITIATORS-1:0][31:0] i_adr;
  logic [N_INITIATORS-1:0][31:0] i_dat_w;
  logic [N_INITIATORS-1:0][31:0] i_dat_r;
  logic [N_INITIATORS-1:0]       i_cyc;
  logic [N_INITIATORS-1:0]       i_stb;
  logic [N_INITIATORS-1:0]       i_we;
  logic [N_INITIATORS-1:0][3:0]  i_sel;
  logic [N_INITIATORS-1:0]       i_ack;
  logic [N_INITIATORS-1:0]       i_err;

  logic [ADDR_BITS-1:0] sram_adr;
  logic [31:0]          sram_dat_w;
  logic [31:0]          sram_dat_r;
  logic                 sram_en;
  logic                 sram_we;
  logic [3:0]           sram_sel;

  // Arbiter side: Wishbone target towards initiators, controller towards SRAM.
  modport slave (
    input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel, sram_dat_r,
    output i_dat_r, i_ack, i_err, sram_adr, sram_dat_w, sram_en, sram_we, sram_sel
  );

  // Environment side: drives initiator requests and the SRAM read data.
  modport master (
    output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel, sram_dat_r,
    input  i_dat_r, i_ack, i_err, sram_adr, sram_dat_w, sram_en, sram_we, sram_sel
  );
endinterface

// File: rtl/wb_sram_arb_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Scan from ptr; the first hit wins, later hits are masked by valid.
  always_comb begin
    logic [PW-1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sram_arb.sv
// Arbitrates N Wishbone initiators onto one single-port SRAM with fixed wait states.
module wb_sram_arb
  import wb_sram_arb_pkg::*;
#(
  parameter int          N_INITIATORS = 3,
  parameter int          ADDR_BITS    = 8,
  parameter int          WAIT_STATES  = DEF_WAIT_STATES,
  parameter logic [31:0] BASE_ADR     = DEF_BASE_ADR,
  parameter logic [31:0] ADR_MASK     = DEF_ADR_MASK
) (
  input logic          clk,
  input logic          rst,
  wb_sram_arb_if.slave bus
);

  localparam int PW = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [1:0]              state;
  logic [PW-1:0]           rr_ptr, cur_idx, gnt_idx, nxt_ptr;
  logic [WW-1:0]           wait_cnt;
  logic [ADDR_BITS-1:0]    cur_adr;
  logic [31:0]             cur_dat;
  logic [3:0]              cur_sel;
  logic                    cur_we, cur_err, cur_cyc, in_win;
  logic [N_INITIATORS-1:0] req, gnt;
  logic                    gnt_vld, acc_en, resp_en;

  assign req = bus.i_cyc & bus.i_stb;

  rr_arbiter #(.N(N_INITIATORS), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (gnt),
    .valid (gnt_vld)
  );

  // One-hot grant to index for capturing the winner's fields.
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N_INITIATORS; k++)
      if (gnt[k]) gnt_idx = PW'(k);
  end

  assign nxt_ptr = (gnt_idx == PW'(N_INITIATORS - 1)) ? '0 : gnt_idx + 1'b1;
  assign in_win  = (bus.i_adr[gnt_idx] & ADR_MASK) == (BASE_ADR & ADR_MASK);
  assign cur_cyc = bus.i_cyc[cur_idx];

  // Transaction FSM; the granted initiator dropping cyc abandons the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      cur_idx  <= '0;
      cur_adr  <= '0;
      cur_dat  <= '0;
      cur_sel  <= '0;
      cur_we   <= 1'b0;
      cur_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (gnt_vld) begin
          cur_idx <= gnt_idx;
          cur_adr <= bus.i_adr[gnt_idx][ADDR_BITS+1:2];
          cur_dat <= bus.i_dat_w[gnt_idx];
          cur_sel <= bus.i_sel[gnt_idx];
          cur_we  <= bus.i_we[gnt_idx];
          cur_err <= !in_win;
          rr_ptr  <= nxt_ptr;
          state   <= in_win ? ST_ACCESS : ST_RESP;
        end
        ST_ACCESS: begin
          if (!cur_cyc) state <= ST_IDLE;
          else if (WAIT_STATES > 0) begin
            state    <= ST_WAIT;
            wait_cnt <= WW'(1);
          end else state <= ST_RESP;
        end
        ST_WAIT: begin
          if (!cur_cyc) state <= ST_IDLE;
          else if (wait_cnt == WW'(WAIT_STATES)) state <= ST_RESP;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobe lives only in ACCESS; all SRAM fields are zero otherwise.
  assign acc_en         = !rst && (state == ST_ACCESS) && cur_cyc;
  assign resp_en        = !rst && (state == ST_RESP) && cur_cyc;
  assign bus.sram_en    = acc_en;
  assign bus.sram_we    = acc_en & cur_we;
  assign bus.sram_sel   = acc_en ? cur_sel : 4'h0;
  assign bus.sram_adr   = acc_en ? cur_adr : '0;
  assign bus.sram_dat_w = acc_en ? cur_dat : 32'h0;

  // One-cycle response to the granted port only; read data passes through in RESP.
  always_comb begin
    bus.i_ack   = '0;
    bus.i_err   = '0;
    bus.i_dat_r = '0;
    for (int k = 0; k < N_INITIATORS; k++) begin
      if (resp_en && (cur_idx == PW'(k))) begin
        bus.i_ack[k]   = !cur_err;
        bus.i_err[k]   = cur_err;
        bus.i_dat_r[k] = (!cur_err && !cur_we) ? bus.sram_dat_r : 32'h0;
      end
    end
  end

endmodule
